// File: rtl/fuzzy_1.sv
// Two-input interval type-2 fuzzy controller: grades, 9 rules, centroid defuzzifier.
// One pass takes 11 clk_0 cycles; inputs are captured at step 0 only.
module fuzzy_1 (
    input  logic       Srst,
    input  logic [7:0] Entrada_01,
    input  logic [7:0] Entrada_02,
    input  logic       EN_REGRAS,
    output logic [7:0] saida_defuzzy,
    input  logic       clk_0,
    output logic       Sclk_int,
    output logic [3:0] SSequencia_regras,
    output logic       SReset_Memoria,
    output logic [5:0] FOU_ATIVO,
    output logic [7:0] sFOU_01_UP,
    output logic [7:0] sFOU_02_UP,
    output logic [7:0] sFOU_03_UP,
    output logic [7:0] sFOU_01_LOW,
    output logic [7:0] sFOU_02_LOW,
    output logic [7:0] sFOU_03_LOW,
    output logic [7:0] sFOU_04_UP,
    output logic [7:0] sFOU_05_UP,
    output logic [7:0] sFOU_06_UP,
    output logic [7:0] sFOU_04_LOW,
    output logic [7:0] sFOU_05_LOW,
    output logic [7:0] sFOU_06_LOW,
    output logic [7:0] Ssaida_UP_0,
    output logic [7:0] Ssaida_LOW_0,
    output logic [7:0] Ssaida_UP_1,
    output logic [7:0] Ssaida_LOW_1,
    output logic [7:0] Ssaida_UP_2,
    output logic [7:0] Ssaida_LOW_2
);

    function automatic logic [7:0] sat(input int v);
        if (v < 0)        return 8'd0;
        else if (v > 255) return 8'd255;
        else              return v[7:0];
    endfunction

    function automatic logic [7:0] low_up(input logic [7:0] x);
        if (x <= 8'd48)      return 8'd255;
        else if (x < 8'd112) return sat((112 - int'(x)) * 4);
        else                 return 8'd0;
    endfunction

    function automatic logic [7:0] low_lo(input logic [7:0] x);
        if (x <= 8'd32)     return 8'd192;
        else if (x < 8'd96) return sat((96 - int'(x)) * 3);
        else                return 8'd0;
    endfunction

    function automatic logic [7:0] med_up(input logic [7:0] x);
        if (x < 8'd48)        return 8'd0;
        else if (x <= 8'd112) return sat((int'(x) - 48) * 4);
        else if (x <= 8'd144) return 8'd255;
        else if (x <= 8'd208) return sat((208 - int'(x)) * 4);
        else                  return 8'd0;
    endfunction

    function automatic logic [7:0] med_lo(input logic [7:0] x);
        if (x < 8'd64)        return 8'd0;
        else if (x <= 8'd128) return sat((int'(x) - 64) * 3);
        else if (x <= 8'd192) return sat((192 - int'(x)) * 3);
        else                  return 8'd0;
    endfunction

    function automatic logic [7:0] high_up(input logic [7:0] x);
        if (x <= 8'd144)      return 8'd0;
        else if (x <= 8'd208) return sat((int'(x) - 144) * 4);
        else                  return 8'd255;
    endfunction

    function automatic logic [7:0] high_lo(input logic [7:0] x);
        if (x <= 8'd160)      return 8'd0;
        else if (x <= 8'd224) return sat((int'(x) - 160) * 3);
        else                  return 8'd192;
    endfunction

    logic [3:0]       r_step;
    logic [5:0][7:0]  r_up;
    logic [5:0][7:0]  r_lo;
    logic [5:0]       r_act;
    logic [2:0][7:0]  r_agg_up;
    logic [2:0][7:0]  r_agg_lo;
    logic [7:0]       r_out;

    logic [5:0][7:0]  w_gu;
    logic [5:0][7:0]  w_gl;
    logic [5:0]       w_act;
    logic [1:0]       w_i;
    logic [1:0]       w_j;
    logic [1:0]       w_k;
    logic [2:0]       w_ij;
    logic [7:0]       w_fu;
    logic [7:0]       w_fl;
    logic [7:0]       w_ua;
    logic [7:0]       w_ub;
    logic [7:0]       w_la;
    logic [7:0]       w_lb;
    logic             w_s0;
    logic             w_s10;
    logic             w_rule;
    logic [8:0]       w_f0;
    logic [8:0]       w_f1;
    logic [8:0]       w_f2;
    logic [9:0]       w_sum;
    logic [17:0]      w_num;
    logic [7:0]       w_q;

    always_comb begin
        w_gu[0] = low_up(Entrada_01);
        w_gu[1] = med_up(Entrada_01);
        w_gu[2] = high_up(Entrada_01);
        w_gu[3] = low_up(Entrada_02);
        w_gu[4] = med_up(Entrada_02);
        w_gu[5] = high_up(Entrada_02);
        w_gl[0] = low_lo(Entrada_01);
        w_gl[1] = med_lo(Entrada_01);
        w_gl[2] = high_lo(Entrada_01);
        w_gl[3] = low_lo(Entrada_02);
        w_gl[4] = med_lo(Entrada_02);
        w_gl[5] = high_lo(Entrada_02);
        for (int n = 0; n < 6; n++) w_act[n] = (w_gu[n] != 8'd0);
    end

    assign w_s0   = (r_step == 4'd0);
    assign w_s10  = (r_step == 4'd10);
    assign w_rule = !w_s0 && !w_s10;

    // rule (i,j) for steps 1..9, row-major over input-1 set then input-2 set
    always_comb begin
        {w_i, w_j} = 4'b0000;
        case (r_step)
            4'd1:    {w_i, w_j} = 4'b0000;
            4'd2:    {w_i, w_j} = 4'b0001;
            4'd3:    {w_i, w_j} = 4'b0010;
            4'd4:    {w_i, w_j} = 4'b0100;
            4'd5:    {w_i, w_j} = 4'b0101;
            4'd6:    {w_i, w_j} = 4'b0110;
            4'd7:    {w_i, w_j} = 4'b1000;
            4'd8:    {w_i, w_j} = 4'b1001;
            4'd9:    {w_i, w_j} = 4'b1010;
            default: {w_i, w_j} = 4'b0000;
        endcase
    end

    assign w_ua = r_up[3'(w_i)];
    assign w_ub = r_up[3'(w_j) + 3'd3];
    assign w_la = r_lo[3'(w_i)];
    assign w_lb = r_lo[3'(w_j) + 3'd3];
    assign w_fu = (w_ua < w_ub) ? w_ua : w_ub;
    assign w_fl = (w_la < w_lb) ? w_la : w_lb;
    assign w_ij = 3'(w_i) + 3'(w_j);
    assign w_k  = (w_ij <= 3'd1) ? 2'd0 : (w_ij == 3'd2) ? 2'd1 : 2'd2;

    assign w_f0  = (9'(r_agg_up[0]) + 9'(r_agg_lo[0])) >> 1;
    assign w_f1  = (9'(r_agg_up[1]) + 9'(r_agg_lo[1])) >> 1;
    assign w_f2  = (9'(r_agg_up[2]) + 9'(r_agg_lo[2])) >> 1;
    assign w_sum = 10'(w_f0) + 10'(w_f1) + 10'(w_f2);
    assign w_num = 18'(w_f0) * 18'd32 + 18'(w_f1) * 18'd128
                 + 18'(w_f2) * 18'd224;
    assign w_q   = 8'(w_num / 18'(w_sum));

    always_ff @(posedge clk_0 or negedge Srst) begin
        if (!Srst) begin
            r_step   <= '0;
            r_up     <= '0;
            r_lo     <= '0;
            r_act    <= '0;
            r_agg_up <= '0;
            r_agg_lo <= '0;
            r_out    <= '0;
        end else if (EN_REGRAS) begin
            r_step <= w_s10 ? 4'd0 : r_step + 4'd1;
            unique case (1'b1)
                w_s0: begin
                    r_up     <= w_gu;
                    r_lo     <= w_gl;
                    r_act    <= w_act;
                    r_agg_up <= '0;
                    r_agg_lo <= '0;
                end
                w_s10: begin
                    r_out <= (w_sum == 10'd0) ? 8'd128 : w_q;
                end
                w_rule: begin
                    if (w_fu > r_agg_up[w_k]) r_agg_up[w_k] <= w_fu;
                    if (w_fl > r_agg_lo[w_k]) r_agg_lo[w_k] <= w_fl;
                end
                default: ;
            endcase
        end
    end

    assign saida_defuzzy     = r_out;
    assign Sclk_int          = w_s10;
    assign SSequencia_regras = r_step;
    assign SReset_Memoria    = w_s0 & Srst;
    assign FOU_ATIVO         = r_act;
    assign sFOU_01_UP        = r_up[0];
    assign sFOU_02_UP        = r_up[1];
    assign sFOU_03_UP        = r_up[2];
    assign sFOU_04_UP        = r_up[3];
    assign sFOU_05_UP        = r_up[4];
    assign sFOU_06_UP        = r_up[5];
    assign sFOU_01_LOW       = r_lo[0];
    assign sFOU_02_LOW       = r_lo[1];
    assign sFOU_03_LOW       = r_lo[2];
    assign sFOU_04_LOW       = r_lo[3];
    assign sFOU_05_LOW       = r_lo[4];
    assign sFOU_06_LOW       = r_lo[5];
    assign Ssaida_UP_0       = r_agg_up[0];
    assign Ssaida_UP_1       = r_agg_up[1];
    assign Ssaida_UP_2       = r_agg_up[2];
    assign Ssaida_LOW_0      = r_agg_lo[0];
    assign Ssaida_LOW_1      = r_agg_lo[1];
    assign Ssaida_LOW_2      = r_agg_lo[2];

endmodule

// File: tb/tb_fuzzy_1.sv
// Directed bench for fuzzy_1: hand-computed grades, aggregates and crisp outputs.
// Covers reset, full passes, mid-pass input change, enable freeze and mid-pass reset.
module tb_fuzzy_1;

    logic       clk_0 = 1'b0;
    logic       Srst;
    logic [7:0] Entrada_01;
    logic [7:0] Entrada_02;
    logic       EN_REGRAS;
    logic [7:0] saida_defuzzy;
    logic       Sclk_int;
    logic [3:0] SSequencia_regras;
    logic       SReset_Memoria;
    logic [5:0] FOU_ATIVO;
    logic [7:0] sFOU_01_UP, sFOU_02_UP, sFOU_03_UP;
    logic [7:0] sFOU_01_LOW, sFOU_02_LOW, sFOU_03_LOW;
    logic [7:0] sFOU_04_UP, sFOU_05_UP, sFOU_06_UP;
    logic [7:0] sFOU_04_LOW, sFOU_05_LOW, sFOU_06_LOW;
    logic [7:0] Ssaida_UP_0, Ssaida_LOW_0;
    logic [7:0] Ssaida_UP_1, Ssaida_LOW_1;
    logic [7:0] Ssaida_UP_2, Ssaida_LOW_2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_0 = ~clk_0;

    fuzzy_1 dut (
        .Srst(Srst),
        .Entrada_01(Entrada_01),
        .Entrada_02(Entrada_02),
        .EN_REGRAS(EN_REGRAS),
        .saida_defuzzy(saida_defuzzy),
        .clk_0(clk_0),
        .Sclk_int(Sclk_int),
        .SSequencia_regras(SSequencia_regras),
        .SReset_Memoria(SReset_Memoria),
        .FOU_ATIVO(FOU_ATIVO),
        .sFOU_01_UP(sFOU_01_UP),
        .sFOU_02_UP(sFOU_02_UP),
        .sFOU_03_UP(sFOU_03_UP),
        .sFOU_01_LOW(sFOU_01_LOW),
        .sFOU_02_LOW(sFOU_02_LOW),
        .sFOU_03_LOW(sFOU_03_LOW),
        .sFOU_04_UP(sFOU_04_UP),
        .sFOU_05_UP(sFOU_05_UP),
        .sFOU_06_UP(sFOU_06_UP),
        .sFOU_04_LOW(sFOU_04_LOW),
        .sFOU_05_LOW(sFOU_05_LOW),
        .sFOU_06_LOW(sFOU_06_LOW),
        .Ssaida_UP_0(Ssaida_UP_0),
        .Ssaida_LOW_0(Ssaida_LOW_0),
        .Ssaida_UP_1(Ssaida_UP_1),
        .Ssaida_LOW_1(Ssaida_LOW_1),
        .Ssaida_UP_2(Ssaida_UP_2),
        .Ssaida_LOW_2(Ssaida_LOW_2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sync0();
        int n = 0;
        do begin
            @(negedge clk_0);
            n++;
        end while (SSequencia_regras != 4'd0 && n < 20);
        chk("sync_step0", 32'(n < 20), 1);
    endtask

    // set inputs just before the step-0 edge and run to the end of the pass
    task automatic run_pass(input logic [7:0] a, input logic [7:0] b,
                            input bit garble);
        sync0();
        Entrada_01 = a;
        Entrada_02 = b;
        @(posedge clk_0);
        if (garble) begin
            @(negedge clk_0);
            Entrada_01 = ~a;
            Entrada_02 = ~b;
        end
        repeat (9) @(posedge clk_0);
        @(negedge clk_0);
        chk("step10", 32'(SSequencia_regras), 10);
        chk("sclk_hi", 32'(Sclk_int), 1);
        @(posedge clk_0);
        @(negedge clk_0);
    endtask

    initial begin
        Srst       = 1'b0;
        EN_REGRAS  = 1'b1;
        Entrada_01 = 8'd0;
        Entrada_02 = 8'd0;
        @(negedge clk_0);
        @(negedge clk_0);
        chk("rst_step", 32'(SSequencia_regras), 0);
        chk("rst_out", 32'(saida_defuzzy), 0);
        chk("rst_act", 32'(FOU_ATIVO), 0);
        chk("rst_mem", 32'(SReset_Memoria), 0);
        chk("rst_sclk", 32'(Sclk_int), 0);
        Srst = 1'b1;

        run_pass(8'd1, 8'd1, 1'b0);
        chk("p1_act", 32'(FOU_ATIVO), 32'b001001);
        chk("p1_up0", 32'(Ssaida_UP_0), 255);
        chk("p1_lo0", 32'(Ssaida_LOW_0), 192);
        chk("p1_up1", 32'(Ssaida_UP_1), 0);
        chk("p1_out", 32'(saida_defuzzy), 32);
        chk("p1_mem", 32'(SReset_Memoria), 1);

        run_pass(8'd254, 8'd254, 1'b0);
        chk("p2_act", 32'(FOU_ATIVO), 32'b100100);
        chk("p2_up2", 32'(Ssaida_UP_2), 255);
        chk("p2_out", 32'(saida_defuzzy), 224);

        run_pass(8'd128, 8'd128, 1'b0);
        chk("p3_act", 32'(FOU_ATIVO), 32'b010010);
        chk("p3_up1", 32'(Ssaida_UP_1), 255);
        chk("p3_lo1", 32'(Ssaida_LOW_1), 192);
        chk("p3_out", 32'(saida_defuzzy), 128);

        run_pass(8'd112, 8'd160, 1'b1);
        chk("p4_g2u", 32'(sFOU_02_UP), 255);
        chk("p4_g2l", 32'(sFOU_02_LOW), 144);
        chk("p4_g5u", 32'(sFOU_05_UP), 192);
        chk("p4_g6u", 32'(sFOU_06_UP), 64);
        chk("p4_up1", 32'(Ssaida_UP_1), 192);
        chk("p4_lo1", 32'(Ssaida_LOW_1), 96);
        chk("p4_up2", 32'(Ssaida_UP_2), 64);
        chk("p4_lo2", 32'(Ssaida_LOW_2), 0);
        chk("p4_out", 32'(saida_defuzzy), 145);

        run_pass(8'd48, 8'd208, 1'b0);
        chk("p5_act", 32'(FOU_ATIVO), 32'b100001);
        chk("p5_g1l", 32'(sFOU_01_LOW), 144);
        chk("p5_g2u", 32'(sFOU_02_UP), 0);
        chk("p5_g6u", 32'(sFOU_06_UP), 255);
        chk("p5_g6l", 32'(sFOU_06_LOW), 144);
        chk("p5_up1", 32'(Ssaida_UP_1), 255);
        chk("p5_lo1", 32'(Ssaida_LOW_1), 144);
        chk("p5_out", 32'(saida_defuzzy), 128);

        sync0();
        Entrada_01 = 8'd112;
        Entrada_02 = 8'd160;
        repeat (5) @(posedge clk_0);
        @(negedge clk_0);
        EN_REGRAS = 1'b0;
        repeat (20) @(posedge clk_0);
        @(negedge clk_0);
        chk("frz_step", 32'(SSequencia_regras), 5);
        chk("frz_out", 32'(saida_defuzzy), 128);
        chk("frz_up1", 32'(Ssaida_UP_1), 0);
        chk("frz_g5u", 32'(sFOU_05_UP), 192);
        chk("frz_sclk", 32'(Sclk_int), 0);
        EN_REGRAS = 1'b1;
        repeat (6) @(posedge clk_0);
        @(negedge clk_0);
        chk("frz_up1b", 32'(Ssaida_UP_1), 192);
        chk("frz_up2b", 32'(Ssaida_UP_2), 64);
        chk("frz_res", 32'(saida_defuzzy), 145);

        sync0();
        Entrada_01 = 8'd1;
        Entrada_02 = 8'd1;
        repeat (3) @(posedge clk_0);
        @(negedge clk_0);
        Srst = 1'b0;
        #1;
        chk("mrst_step", 32'(SSequencia_regras), 0);
        chk("mrst_out", 32'(saida_defuzzy), 0);
        chk("mrst_act", 32'(FOU_ATIVO), 0);
        chk("mrst_g1u", 32'(sFOU_01_UP), 0);
        chk("mrst_up0", 32'(Ssaida_UP_0), 0);
        chk("mrst_mem", 32'(SReset_Memoria), 0);
        @(negedge clk_0);
        Srst = 1'b1;

        run_pass(8'd254, 8'd254, 1'b0);
        chk("p6_out", 32'(saida_defuzzy), 224);
        chk("p6_act", 32'(FOU_ATIVO), 32'b100100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fuzzy_1.md
FUZZY_1 -- requirements
Module: fuzzy_1

Interface
REQ-001 The block SHALL have no parameters; all membership breakpoints and centroids are fixed constants.
REQ-002 clk_0  input  1  sole clock; all state updates on rising edge.
REQ-003 Srst  input  1  asynchronous, active-low reset.
REQ-004 Entrada_01, Entrada_02  input  8 each  crisp inputs, unsigned 0..255.
REQ-005 EN_REGRAS  input  1  run enable; 0 freezes sequencer and all registers.
REQ-006 saida_defuzzy  output  8  registered crisp output.
REQ-007 Sclk_int  output  1  update strobe, high during step 10.
REQ-008 SSequencia_regras  output  4  current step counter, 0..10.
REQ-009 SReset_Memoria  output  1  high during step 0 (aggregation memory clear).
REQ-010 FOU_ATIVO  output  6  active-set flags; bits [2:0] = sets 1..3 of input 1, bits [5:3] = sets 1..3 of input 2.
REQ-011 sFOU_0n_UP / sFOU_0n_LOW (n=1..6)  output  8 each  registered upper/lower grades; n=1..3 Low/Med/High of Entrada_01, n=4..6 Low/Med/High of Entrada_02.
REQ-012 Ssaida_UP_k / Ssaida_LOW_k (k=0..2)  output  8 each  aggregated upper/lower firing of output set k.
REQ-013 Port order: Srst, Entrada_01, Entrada_02, EN_REGRAS, saida_defuzzy, clk_0, Sclk_int, SSequencia_regras, SReset_Memoria, FOU_ATIVO, sFOU_01_UP, sFOU_02_UP, sFOU_03_UP, sFOU_01_LOW, sFOU_02_LOW, sFOU_03_LOW, sFOU_04_UP, sFOU_05_UP, sFOU_06_UP, sFOU_04_LOW, sFOU_05_LOW, sFOU_06_LOW, Ssaida_UP_0, Ssaida_LOW_0, Ssaida_UP_1, Ssaida_LOW_1, Ssaida_UP_2, Ssaida_LOW_2.

Function
REQ-014 Membership (identical for both inputs, x = input, results clamped to 0..255): Low UP = 255 for x<=48, (112-x)*4 for 48<x<112, else 0; Low LOW = 192 for x<=32, (96-x)*3 for 32<x<96, else 0.
REQ-015 Med UP = (x-48)*4 on 48..112, 255 on 112..144, (208-x)*4 on 144..208, else 0; Med LOW = (x-64)*3 on 64..128, (192-x)*3 on 128..192, else 0.
REQ-016 High UP = 0 for x<=144, (x-144)*4 on 144..208, 255 beyond; High LOW = 0 for x<=160, (x-160)*3 on 160..224, 192 beyond.
REQ-017 Step counter runs 0,1,..,10,0 while EN_REGRAS=1; pass period 11 clk_0 cycles.
REQ-018 Step 0: sample inputs, register all 12 grades into sFOU_*, update FOU_ATIVO (bit=1 iff UP grade nonzero), clear all Ssaida_* to 0.
REQ-019 Steps 1..9: evaluate rule (i,j) with i = input-1 set, j = input-2 set, order (L,L),(L,M),(L,H),(M,L),(M,M),(M,H),(H,L),(H,M),(H,H); one rule per cycle.
REQ-020 Rule firing: upper = min of the two UP grades, lower = min of the two LOW grades.
REQ-021 Consequent set k: (L,L),(L,M),(M,L)->0; (L,H),(M,M),(H,L)->1; (M,H),(H,M),(H,H)->2.
REQ-022 Aggregation: Ssaida_UP_k = max(Ssaida_UP_k, upper), Ssaida_LOW_k = max(Ssaida_LOW_k, lower).
REQ-023 Step 10: f_k = (UP_k+LOW_k)>>1 (9-bit sum); centroids c0=32, c1=128, c2=224; saida_defuzzy = floor(sum f_k*c_k / sum f_k), or 128 if sum f_k = 0; register holds until next step 10.
REQ-024 Inputs changing mid-pass SHALL NOT affect the pass in progress.
REQ-025 EN_REGRAS=0 holds counter and all outputs; resume continues from held step.

Reset
REQ-026 Srst=0 asynchronously clears counter to 0 and every output (including saida_defuzzy, FOU_ATIVO, all grades/aggregates, Sclk_int) to 0; first pass starts at step 0 after release.

Verification
REQ-027 Srst=0 mid-pass -> all outputs 0 immediately, SSequencia_regras=0.
REQ-028 Entrada_01=1, Entrada_02=1 -> FOU_ATIVO=6'b001001, Ssaida_UP_0=255, Ssaida_LOW_0=192, saida_defuzzy=32.
REQ-029 254,254 -> FOU_ATIVO=6'b100100, saida_defuzzy=224.
REQ-030 128,128 -> FOU_ATIVO=6'b010010, Ssaida_UP_1=255, Ssaida_LOW_1=192, saida_defuzzy=128.
REQ-031 112,160 -> Ssaida_UP_1=192, Ssaida_LOW_1=96, Ssaida_UP_2=64, Ssaida_LOW_2=0, saida_defuzzy=145.
REQ-032 EN_REGRAS=0 at step 5 for 20 cycles -> SSequencia_regras stays 5, outputs unchanged; result after re-enable matches uninterrupted pass.
